// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack.
// Drives the PC onto the shared bus and supports inc, load, relative branch, call and return.
module pc_stack #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_read_n,
  input  logic                         i_write_n,
  input  logic                         i_inc_n,
  input  logic                         i_rel_n,
  input  logic                         i_call_n,
  input  logic                         i_ret_n,
  input  logic                         i_clr_err_n,
  inout  wire  [WIDTH-1:0]             io_bus,
  output logic [WIDTH-1:0]             o_pc,
  output logic [$clog2(DEPTH+1)-1:0]   o_sp,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [WIDTH-1:0]        pc_q, pc_d;
  logic [SPW-1:0]          sp_q, sp_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic [WIDTH-1:0]        stack_q [DEPTH];
  logic [WIDTH-1:0]        top;
  logic [WIDTH-1:0]        ret_addr;
  logic signed [WIDTH-1:0] rel_off;
  logic                    push;

  function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  assign io_bus   = i_read_n ? {WIDTH{1'bz}} : pc_q;
  assign ret_addr = incr(pc_q);
  assign rel_off  = $signed(io_bus);

  // Top-of-stack mux; index by equality so sp never needs narrowing.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q & i_clr_err_n;
    unf_d = unf_q & i_clr_err_n;
    push  = 1'b0;
    if (!i_ret_n) begin
      if (sp_q != '0) begin
        pc_d = top;
        sp_d = sp_q - SPW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (!i_call_n) begin
      if (sp_q != SP_FULL) begin
        push = 1'b1;
        pc_d = io_bus;
        sp_d = sp_q + SPW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (!i_write_n) begin
      pc_d = io_bus;
    end else if (!i_rel_n) begin
      pc_d = pc_q + $unsigned(rel_off);
    end else if (!i_inc_n) begin
      pc_d = incr(pc_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage carries no reset; entries above sp are never read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SPW'(i)) stack_q[i] <= ret_addr;
      end
    end
  end

  assign o_pc        = pc_q;
  assign o_sp        = sp_q;
  assign o_full      = (sp_q == SP_FULL);
  assign o_empty     = (sp_q == '0);
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios plus random strobes against a queue-based model.
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic       read_n, write_n, inc_n, rel_n, call_n, ret_n, clr_n;
  logic [7:0] tb_bus;
  logic       tb_drv;
  wire  [7:0] io_bus;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       full, empty, ovf, unf;

  int vecs = 0;
  int errs = 0;

  logic [7:0] pc_m;
  logic [7:0] stk[$];
  logic       ovf_m, unf_m;

  always #5 clk = ~clk;

  assign io_bus = tb_drv ? tb_bus : 8'bzzzzzzzz;

  pc_stack #(.WIDTH(8), .DEPTH(4), .RESET_VECTOR(8'h20)) dut (
    .i_clk(clk), .i_reset(rst), .i_read_n(read_n), .i_write_n(write_n),
    .i_inc_n(inc_n), .i_rel_n(rel_n), .i_call_n(call_n), .i_ret_n(ret_n),
    .i_clr_err_n(clr_n), .io_bus(io_bus), .o_pc(pc), .o_sp(sp),
    .o_full(full), .o_empty(empty), .o_overflow(ovf), .o_underflow(unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_m  = 8'h20;
    stk   = {};
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic model_edge(input logic r_n, w_n, i_n, rl_n, c_n, rt_n, cl_n,
                            input logic [7:0] b);
    logic [7:0] bv;
    bv = r_n ? b : pc_m;
    if (!cl_n) begin ovf_m = 1'b0; unf_m = 1'b0; end
    if (!rt_n) begin
      if (stk.size() > 0) pc_m = stk.pop_back();
      else unf_m = 1'b1;
    end else if (!c_n) begin
      if (stk.size() < 4) begin
        stk.push_back(8'((int'(pc_m) + 1) % 256));
        pc_m = bv;
      end else ovf_m = 1'b1;
    end else if (!w_n) pc_m = bv;
    else if (!rl_n) pc_m = 8'((int'(pc_m) + int'($signed(bv)) + 256) % 256);
    else if (!i_n) pc_m = 8'((int'(pc_m) + 1) % 256);
  endtask

  task automatic check_all();
    chk("pc", pc, pc_m);
    chk("sp", sp, stk.size());
    chk("full", full, stk.size() == 4);
    chk("empty", empty, stk.size() == 0);
    chk("ovf", ovf, ovf_m);
    chk("unf", unf, unf_m);
  endtask

  task automatic step(input logic r_n, w_n, i_n, rl_n, c_n, rt_n, cl_n,
                      input logic [7:0] b);
    @(negedge clk);
    read_n = r_n; write_n = w_n; inc_n = i_n; rel_n = rl_n;
    call_n = c_n; ret_n = rt_n; clr_n = cl_n;
    tb_bus = b; tb_drv = r_n;
    #1;
    if (!r_n) chk("bus_rd", io_bus, pc_m);
    else chk("bus_in", io_bus, b);
    @(posedge clk);
    #1;
    model_edge(r_n, w_n, i_n, rl_n, c_n, rt_n, cl_n, b);
    check_all();
  endtask

  task automatic idle();
    read_n = 1; write_n = 1; inc_n = 1; rel_n = 1;
    call_n = 1; ret_n = 1; clr_n = 1; tb_drv = 0; tb_bus = 8'h00;
  endtask

  initial begin
    logic [7:0] rets [5];
    rets = '{8'hC1, 8'hB1, 8'hA1, 8'h11, 8'h11};
    idle();
    rst = 1'b1;
    model_reset();
    #12;
    read_n = 1'b0;
    #1;
    chk("rst_pc", pc, 8'h20);
    chk("rst_sp", sp, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flags", {ovf, unf}, 2'b00);
    chk("rst_bus", io_bus, 8'h20);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Increment wrap and write-over-inc priority
    step(1, 0, 1, 1, 1, 1, 1, 8'hFF);
    step(1, 1, 0, 1, 1, 1, 1, 8'h00);
    chk("inc_wrap", pc, 8'h00);
    step(1, 0, 0, 1, 1, 1, 1, 8'h40);
    chk("write_wins", pc, 8'h40);

    // Relative branch both directions
    step(1, 0, 1, 1, 1, 1, 1, 8'h10);
    step(1, 1, 1, 0, 1, 1, 1, 8'hFE);
    chk("rel_neg", pc, 8'h0E);
    step(1, 0, 1, 1, 1, 1, 1, 8'h10);
    step(1, 1, 1, 0, 1, 1, 1, 8'h05);
    chk("rel_pos", pc, 8'h15);

    // Single call/return
    step(1, 0, 1, 1, 1, 1, 1, 8'h10);
    step(1, 1, 1, 1, 0, 1, 1, 8'h80);
    chk("call_pc", pc, 8'h80);
    chk("call_sp", sp, 1);
    step(1, 1, 1, 1, 1, 0, 1, 8'h00);
    chk("ret_pc", pc, 8'h11);
    chk("ret_sp", sp, 0);

    // Fill to overflow, drain to underflow, clear flags
    step(1, 0, 1, 1, 1, 1, 1, 8'h10);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, 1, 1, 8'hA0 + 8'(i) * 8'h10);
    chk("full_sp", sp, 4);
    chk("full_flag", full, 1);
    chk("ovf_flag", ovf, 1);
    chk("full_pc", pc, 8'hD0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 1, 1, 0, 1, 8'h00);
      chk("lifo_pc", pc, rets[i]);
    end
    chk("unf_flag", unf, 1);
    step(1, 1, 1, 1, 1, 1, 0, 8'h00);
    chk("clr_flags", {ovf, unf}, 2'b00);

    // Load while driving the bus: PC reloads itself; then ret error with clear
    step(0, 0, 1, 1, 1, 1, 1, 8'h00);
    step(1, 1, 1, 1, 1, 0, 0, 8'h00);
    chk("err_wins", unf, 1);

    // Asynchronous reset between edges mid call sequence
    step(1, 1, 1, 1, 0, 1, 1, 8'h55);
    step(1, 1, 1, 1, 0, 1, 1, 8'h66);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_pc", pc, 8'h20);
    chk("arst_sp", sp, 0);
    chk("arst_empty", empty, 1);
    chk("arst_flags", {ovf, unf}, 2'b00);
    #1 rst = 1'b0;

    // Random strobes
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(3) != 0), ($urandom_range(4) != 0), ($urandom_range(2) != 0),
           ($urandom_range(4) != 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           ($urandom_range(7) != 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated return-address stack for the CPU datapath. It holds the instruction address, drives it onto the shared tri-state bus on request, and supports increment, absolute load, signed relative branch, call (push) and return (pop). It replaces the fixed 8-bit counter. Sequencer control strobes are active-low.

## Interface
- WIDTH, 8: address/bus width in bits (≥ 2).
- DEPTH, 4: return-stack entries (≥ 1).
- RESET_VECTOR, 0: PC value after reset (WIDTH bits).
- i_clk  in  1  system clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_read_n  in  1  low: drive PC onto io_bus.
- i_write_n  in  1  low: load PC from io_bus.
- i_inc_n  in  1  low: PC ← PC + 1.
- i_rel_n  in  1  low: PC ← PC + signed(io_bus).
- i_call_n  in  1  low: push PC + 1, load PC from io_bus.
- i_ret_n  in  1  low: pop top of stack into PC.
- i_clr_err_n  in  1  low: clear sticky error flags.
- io_bus  inout  WIDTH  shared data bus.
- o_pc  out  WIDTH  current PC (debug/fetch address).
- o_sp  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
- o_full  out  1  o_sp == DEPTH.
- o_empty  out  1  o_sp == 0.
- o_overflow  out  1  sticky: call attempted while full.
- o_underflow  out  1  sticky: return attempted while empty.

## Operation
- io_bus = PC when i_read_n low, else high-Z; combinational, no clock latency.
- Per rising edge exactly one operation executes, chosen by fixed priority: ret > call > write > rel > inc. Lower-priority strobes asserted in the same cycle are ignored.
- inc: PC ← (PC + 1) mod 2^WIDTH; all-ones wraps to 0.
- write: PC ← io_bus.
- rel: PC ← (PC + io_bus) mod 2^WIDTH, io_bus interpreted as two's complement; e.g. WIDTH=8, PC=0x10, bus=0xFE → 0x0E.
- call, not full: stack[sp] ← (PC + 1) mod 2^WIDTH, sp ← sp + 1, PC ← io_bus.
- call, full: no push, PC unchanged, o_overflow ← 1.
- ret, not empty: PC ← stack[sp − 1], sp ← sp − 1.
- ret, empty: PC unchanged, o_underflow ← 1.
- i_clr_err_n low clears both sticky flags; a new error in the same cycle wins (flag ends 1).
- i_read_n with any load-type op: op samples whatever is on io_bus (PC itself when driven by this block); no special casing.
- No operation asserted: all state holds.

## Timing
- Reset (async assert, any time incl. mid-operation): PC = RESET_VECTOR, sp = 0, o_overflow = o_underflow = 0, o_empty = 1, o_full = 0; stack contents undefined and unobservable.
- Reset deassertion: first operation takes effect on the first rising edge after deassertion.
- All ops single-cycle: new PC/sp/flags visible immediately after the edge that samples the strobe.
- o_pc, o_sp, o_full, o_empty are registered-state decodes; no combinational path from strobes.
- Back-to-back call/ret in consecutive cycles supported at full rate.

## Test plan
- Reset with RESET_VECTOR=0x20, WIDTH=8 -> o_pc=0x20, o_sp=0, o_empty=1, flags 0, io_bus Z with i_read_n high.
- PC=0xFF, i_inc_n low one cycle -> o_pc=0x00; i_write_n and i_inc_n low together, bus=0x40 -> o_pc=0x40 (write wins).
- PC=0x10, i_rel_n low, bus=0xFE -> 0x0E; then bus=0x05 -> 0x13.
- PC=0x10, call with bus=0x80 -> o_pc=0x80, o_sp=1; ret -> o_pc=0x11, o_sp=0.
- DEPTH=4: five calls -> o_sp=4, o_full=1, o_overflow=1, PC equals 4th target; five rets -> return addresses in LIFO order, o_underflow=1, PC holds last popped value; i_clr_err_n low -> both flags 0.
- i_reset pulsed asynchronously between edges mid call sequence -> outputs at reset values immediately, before next clock edge.
